// File: rtl/text_console_writer.sv
// text_console_writer: byte-stream console feeding video memory port A, with cursor, control codes and scroll-by-top_row.
module text_console_writer #(
  parameter int COLS = 32,
  parameter int ROWS = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        vm_we,
  output logic [11:0] vm_addr,
  output logic [7:0]  vm_din,
  output logic [4:0]  cur_row,
  output logic [4:0]  cur_col,
  output logic [4:0]  top_row,
  output logic        busy
);
  localparam int CB = $clog2(COLS);
  localparam logic [9:0] LAST = 10'(ROWS * COLS - 1);
  localparam logic [4:0] RMAX = 5'(ROWS - 1);
  localparam logic [4:0] CMAX = 5'(COLS - 1);
  typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_SCREEN} state_t;
  state_t state, state_n;
  logic [9:0] cnt, cnt_n;
  logic [4:0] row_n, col_n, top_n, phys;
  logic [5:0] sum;
  logic [11:0] addr_n;
  logic [7:0] din_n;
  logic we_n, busy_n, bs, bs_n, nl, take;
  assign sum = {1'b0, top_row} + {1'b0, cur_row};
  assign phys = sum > 6'(ROWS - 1) ? 5'(sum - 6'(ROWS)) : sum[4:0];
  assign char_ready = state == IDLE;
  assign take = char_ready && char_valid;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    row_n = cur_row;
    col_n = cur_col;
    top_n = top_row;
    we_n = 1'b0;
    busy_n = 1'b0;
    addr_n = vm_addr;
    din_n = vm_din;
    bs_n = bs;
    nl = 1'b0;
    case (state)
      IDLE: if (take) begin
        if (char_data == 8'h0D) col_n = 5'd0;
        else if (char_data == 8'h0A) nl = 1'b1;
        else if (char_data == 8'h0C) begin
          state_n = CLR_SCREEN;
          cnt_n = 10'd0;
        end else if (char_data == 8'h08) begin
          if (cur_col != 5'd0) begin
            col_n = cur_col - 5'd1;
            we_n = 1'b1;
            addr_n = {2'b00, phys, cur_col - 5'd1};
            din_n = BLANK;
            bs_n = 1'b1;
            state_n = WRITE;
          end
        end else begin
          we_n = 1'b1;
          addr_n = {2'b00, phys, cur_col};
          din_n = char_data;
          bs_n = 1'b0;
          state_n = WRITE;
        end
      end
      // a backspace already moved the cursor when it was accepted
      WRITE: begin
        state_n = IDLE;
        if (!bs) begin
          col_n = cur_col == CMAX ? 5'd0 : cur_col + 5'd1;
          nl = cur_col == CMAX;
        end
      end
      CLR_LINE: begin
        we_n = 1'b1;
        busy_n = 1'b1;
        addr_n = {2'b00, phys, cnt[4:0]};
        din_n = BLANK;
        cnt_n = cnt + 10'd1;
        state_n = cnt[4:0] == CMAX ? IDLE : CLR_LINE;
      end
      CLR_SCREEN: begin
        we_n = 1'b1;
        busy_n = 1'b1;
        addr_n = {2'b00, 5'(cnt >> CB), 5'(cnt & 10'(COLS - 1))};
        din_n = BLANK;
        cnt_n = cnt + 10'd1;
        if (cnt == LAST) begin
          state_n = IDLE;
          row_n = 5'd0;
          col_n = 5'd0;
          top_n = 5'd0;
        end
      end
    endcase
    // at the bottom, scrolling moves top_row so phys now points at the stale old top row
    if (nl) begin
      if (cur_row != RMAX) begin
        row_n = cur_row + 5'd1;
        state_n = IDLE;
      end else begin
        top_n = top_row == RMAX ? 5'd0 : top_row + 5'd1;
        cnt_n = 10'd0;
        state_n = CLR_LINE;
      end
    end
  end
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      state <= CLR_SCREEN;
      cnt <= 10'd0;
      cur_row <= 5'd0;
      cur_col <= 5'd0;
      top_row <= 5'd0;
      vm_we <= 1'b0;
      vm_addr <= 12'd0;
      vm_din <= 8'd0;
      busy <= 1'b0;
      bs <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cur_row <= row_n;
      cur_col <= col_n;
      top_row <= top_n;
      vm_we <= we_n;
      vm_addr <= addr_n;
      vm_din <= din_n;
      busy <= busy_n;
      bs <= bs_n;
    end
  end
endmodule
